// File: rtl/issue_queue_mw_pkg.sv
// Shared constants, width helpers and issue-count encodings for the multi-way issue queue.
package issue_queue_mw_pkg;

    // Decoded-instruction bus width and default lane/queue geometry
    localparam int DECODE_BUS_WD = 256;
    localparam int ENQ_LANES     = 2;
    localparam int DEQ_LANES     = 2;
    localparam int QUEUE_DEPTH   = 16;

    // Issue-count field: generalises the old single/dual issue modes to 0..4 lanes
    typedef enum logic [2:0] {
        ISSUE_NONE   = 3'd0,
        ISSUE_SINGLE = 3'd1,
        ISSUE_DUAL   = 3'd2,
        ISSUE_TRIPLE = 3'd3,
        ISSUE_QUAD   = 3'd4
    } issue_cnt_e;

    // Pointer width for a power-of-two depth (at least one bit)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter holding values 0..n inclusive
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/issue_queue_lane_mux.sv
// Read-port mux for one presentation lane: selects entry (head + LANE) with natural wrap.
module issue_queue_lane_mux
    import issue_queue_mw_pkg::*;
#(
    parameter int DATA_W = DECODE_BUS_WD,
    parameter int DEPTH  = QUEUE_DEPTH,
    parameter int LANE   = 0,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic [PTR_W-1:0]  head,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] rd_idx;

    // Pointer add wraps modulo DEPTH because DEPTH is a power of two
    always_comb begin
        rd_idx = head + PTR_W'(LANE);
        data   = mem[rd_idx];
    end

endmodule

// File: rtl/issue_queue_mw.sv
// Multi-way in-order issue queue: up to ENQ_N writes per cycle, oldest DEQ_N entries presented,
// 0..DEQ_N retired per cycle, with exact occupancy, almost-full and burst-sized space check.
module issue_queue_mw
    import issue_queue_mw_pkg::*;
#(
    parameter int DATA_W    = DECODE_BUS_WD,
    parameter int DEPTH     = QUEUE_DEPTH,
    parameter int ENQ_N     = ENQ_LANES,
    parameter int DEQ_N     = DEQ_LANES,
    parameter int AF_THRESH = DEPTH - 4,
    localparam int CNT_W    = cnt_width(DEPTH),
    localparam int DCNT_W   = cnt_width(DEQ_N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [ENQ_N-1:0]        in_valid,
    input  logic [ENQ_N*DATA_W-1:0] in_data,
    output logic                    in_ready,
    output logic [DEQ_N-1:0]        out_valid,
    output logic [DEQ_N*DATA_W-1:0] out_data,
    input  logic [DCNT_W-1:0]       deq_cnt,
    output logic [CNT_W-1:0]        count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ECNT_W = cnt_width(ENQ_N);

    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] lane_data [ENQ_N];
    logic [ECNT_W-1:0] enq_n;
    logic [ECNT_W-1:0] enq_acc;
    logic [CNT_W-1:0]  deq_ext;
    logic [CNT_W-1:0]  deq_eff;
    logic [ENQ_N-1:0]  valid_inc;

    // Split the flat input bus into per-lane words
    generate
        for (genvar gi = 0; gi < ENQ_N; gi++) begin : g_in_lane
            assign lane_data[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Leading-ones count of in_valid from lane 0; lanes after the first gap are ignored
    always_comb begin
        logic run;
        enq_n = '0;
        run   = 1'b1;
        for (int i = 0; i < ENQ_N; i++) begin
            if (run && in_valid[i]) begin
                enq_n = enq_n + ECNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Space check uses registered occupancy only, so deq_cnt never reaches in_ready
    always_comb begin
        in_ready = ({1'b0, count_reg} + (CNT_W+1)'(ENQ_N)) <= (CNT_W+1)'(DEPTH);
        enq_acc  = in_ready ? enq_n : '0;
        deq_ext  = CNT_W'(deq_cnt);
        deq_eff  = (deq_ext > count_reg) ? count_reg : deq_ext;
    end

    // Next-state pointers and occupancy; flush overrides any traffic this cycle
    always_comb begin
        head_next  = head_reg + PTR_W'(deq_eff);
        tail_next  = tail_reg + PTR_W'(enq_acc);
        count_next = count_reg + CNT_W'(enq_acc) - deq_eff;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage writes for accepted lanes; storage itself is never cleared
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < ENQ_N; i++) begin
                if (ECNT_W'(i) < enq_acc) begin
                    mem[tail_reg + PTR_W'(i)] <= lane_data[i];
                end
            end
        end
    end

    // Presentation lanes: oldest DEQ_N entries starting at head
    generate
        for (genvar gi = 0; gi < DEQ_N; gi++) begin : g_out_lane
            issue_queue_lane_mux #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .LANE   (gi)
            ) u_lane_mux (
                .mem  (mem),
                .head (head_reg),
                .data (out_data[gi*DATA_W +: DATA_W])
            );
            assign out_valid[gi] = count_reg > CNT_W'(gi);
        end
    endgenerate

    // Status flags derived from registered occupancy
    always_comb begin
        count       = count_reg;
        empty       = (count_reg == '0);
        full        = (count_reg == CNT_W'(DEPTH));
        almost_full = (count_reg >= CNT_W'(AF_THRESH));
    end

    assign valid_inc = in_valid + ENQ_N'(1);

    // Protocol checks on the producer and selector interfaces (simulation only)
    always @(posedge clk) begin
        if (!reset) begin
            assert (deq_ext <= count_reg)
                else $warning("issue_queue_mw: deq_cnt %0d exceeds count %0d", deq_cnt, count_reg);
            assert ((in_valid & valid_inc) == '0)
                else $warning("issue_queue_mw: in_valid %b not prefix-contiguous", in_valid);
            for (int k = 0; k < DEQ_N; k++) begin
                if (deq_ext > CNT_W'(k)) begin
                    assert (out_valid[k])
                        else $warning("issue_queue_mw: retiring lane %0d while it is not valid", k);
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_mw.sv
// Self-checking bench for issue_queue_mw: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_issue_queue_mw;

    localparam int DW = 256;

    logic           clk;
    logic           reset;
    logic           flush;
    logic [1:0]     in_valid;
    logic [2*DW-1:0] in_data;
    logic           in_ready;
    logic [1:0]     out_valid;
    logic [2*DW-1:0] out_data;
    logic [1:0]     deq_cnt;
    logic [4:0]     count;
    logic           empty;
    logic           full;
    logic           almost_full;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq [$];

    issue_queue_mw dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .deq_cnt     (deq_cnt),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int j = 0; j < DW/32; j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Compare every visible output against the model's view of the queue
    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, DW'(count), DW'(sz));
        chk({tag, ".empty"}, DW'(empty), DW'(sz == 0));
        chk({tag, ".full"}, DW'(full), DW'(sz == 16));
        chk({tag, ".almost_full"}, DW'(almost_full), DW'(sz >= 12));
        chk({tag, ".in_ready"}, DW'(in_ready), DW'((16 - sz) >= 2));
        chk({tag, ".out_valid"}, DW'(out_valid), DW'({sz > 1, sz > 0}));
        if (sz > 0) chk({tag, ".lane0"}, out_data[DW-1:0], mq[0]);
        if (sz > 1) chk({tag, ".lane1"}, out_data[2*DW-1:DW], mq[1]);
        $display("[%0t] %s v=%b deq=%0d flush=%0b count=%0d ready=%0b", $time, tag,
                 in_valid, deq_cnt, flush, count, in_ready);
    endtask

    // One clock of traffic: apply inputs, advance the model by the same edge, check
    task automatic cycle(input logic [1:0] v, input logic [1:0] d, input logic f,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, input string tag);
        int sz, enq_n, deq_eff;
        bit ready;
        in_valid = v;
        deq_cnt  = d;
        flush    = f;
        in_data  = {d1, d0};
        sz      = mq.size();
        ready   = (16 - sz) >= 2;
        enq_n   = v[0] ? (v[1] ? 2 : 1) : 0;
        deq_eff = (int'(d) < sz) ? int'(d) : sz;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            repeat (deq_eff) void'(mq.pop_front());
            if (ready && enq_n >= 1) mq.push_back(d0);
            if (ready && enq_n >= 2) mq.push_back(d1);
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        in_valid = '0;
        deq_cnt  = '0;
        flush    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = '0;
        deq_cnt  = '0;
        in_data  = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        reset = 1'b0;

        // Reset mid-burst at count=5, checked before the next edge
        cycle(2'b11, 2'd0, 1'b0, rnd256(), rnd256(), "pre_rst");
        cycle(2'b11, 2'd0, 1'b0, rnd256(), rnd256(), "pre_rst");
        cycle(2'b01, 2'd0, 1'b0, rnd256(), rnd256(), "pre_rst");
        chk("pre_rst.count5", DW'(count), DW'(5));
        reset = 1'b1;
        #1;
        mq.delete();
        check_all("async_rst");
        #1;
        reset = 1'b0;
        idle();

        // Fill to full with 2-lane bursts; the ninth burst must be refused
        for (int i = 0; i < 9; i++) cycle(2'b11, 2'd0, 1'b0, rnd256(), rnd256(), "fill");
        chk("fill.full", DW'(full), DW'(1));

        // Drain completely
        for (int i = 0; i < 8; i++) cycle(2'b00, 2'd2, 1'b0, rnd256(), rnd256(), "drain");

        // Wrap: advance both pointers to 14, then write a pair across 15 -> 0
        for (int i = 0; i < 7; i++) cycle(2'b11, 2'd0, 1'b0, rnd256(), rnd256(), "wrap_fill");
        for (int i = 0; i < 7; i++) cycle(2'b00, 2'd2, 1'b0, rnd256(), rnd256(), "wrap_drain");
        cycle(2'b11, 2'd0, 1'b0, DW'(32'hA), DW'(32'hB), "wrap");
        chk("wrap.lane0_A", out_data[DW-1:0], DW'(32'hA));
        chk("wrap.lane1_B", out_data[2*DW-1:DW], DW'(32'hB));
        chk("wrap.count2", DW'(count), DW'(2));

        // Simultaneous enqueue and dequeue at count=3
        cycle(2'b01, 2'd0, 1'b0, rnd256(), rnd256(), "simul_setup");
        cycle(2'b11, 2'd2, 1'b0, rnd256(), rnd256(), "simul");

        // Clamp an over-request, then a non-prefix valid pattern
        cycle(2'b00, 2'd2, 1'b0, rnd256(), rnd256(), "clamp_setup");
        cycle(2'b00, 2'd2, 1'b0, rnd256(), rnd256(), "clamp");
        chk("clamp.empty", DW'(empty), DW'(1));
        cycle(2'b10, 2'd0, 1'b0, rnd256(), rnd256(), "prefix");

        // Flush wins over simultaneous enqueue and dequeue at count=6
        for (int i = 0; i < 3; i++) cycle(2'b11, 2'd0, 1'b0, rnd256(), rnd256(), "flush_setup");
        cycle(2'b11, 2'd1, 1'b1, rnd256(), rnd256(), "flush");
        cycle(2'b11, 2'd0, 1'b0, rnd256(), rnd256(), "post_flush");

        // Random legal traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            logic [1:0] v;
            int d;
            case ($urandom_range(0, 2))
                0:       v = 2'b00;
                1:       v = 2'b01;
                default: v = 2'b11;
            endcase
            d = $urandom_range(0, 2);
            if (d > mq.size()) d = mq.size();
            cycle(v, 2'(d), ($urandom_range(0, 31) == 0), rnd256(), rnd256(), "rand");
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue_mw.md
Name: issue_queue_mw

Overview:
- Parametrised multi-way in-order issue queue between decode and issue logic. Successor to the fixed 2-in/2-out, 16-entry buffer.
- Accepts up to ENQ_N decoded instructions per cycle and presents the oldest DEQ_N entries to the issue selector.
- The selector retires 0..DEQ_N head entries per cycle.
- Adds what the old buffer lacked: exact occupancy tracking, an almost-full threshold, a space check sized to the burst width, and clamping of over-requested dequeues.

Parameters:
- DATA_W, 256, width of one decoded-instruction bus entry.
- DEPTH, 16, number of entries; must be a power of two and ≥ ENQ_N+DEQ_N.
- ENQ_N, 2, enqueue lanes per cycle (1..4).
- DEQ_N, 2, dequeue/presentation lanes per cycle (1..4).
- AF_THRESH, DEPTH-4, occupancy at or above which almost_full is asserted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush: empties the queue on the next edge.
- in_valid  in  ENQ_N  per-lane enqueue valid; lane 0 is the oldest.
- in_data  in  ENQ_N*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  1  queue can accept a full ENQ_N burst this cycle.
- out_valid  out  DEQ_N  head lane k holds a valid entry.
- out_data  out  DEQ_N*DATA_W  lane k = entry head+k, modulo DEPTH.
- deq_cnt  in  clog2(DEQ_N+1)  number of head entries consumed this cycle.
- count  out  clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESH.

Behaviour:
- State: head and tail pointers (clog2(DEPTH) bits, natural wrap), a count register, and storage mem[DEPTH]. Storage is not reset.
- Reset, asynchronous: head=0, tail=0, count=0. Outputs then read out_valid=0, empty=1, full=0, almost_full=0, in_ready=1. out_data is don't-care while out_valid=0.
- Enqueue count:
  - enq_n = number of leading ones of in_valid starting at lane 0; lanes after the first 0 are ignored.
  - A burst is accepted only when in_ready=1. Otherwise nothing is written and the producer holds its inputs.
- in_ready = (DEPTH - count) ≥ ENQ_N. It is combinational from registered count only and does not depend on this cycle's dequeue, so there is no comb path deq_cnt→in_ready.
- Write: on an accepted edge, mem[tail+i] <= lane i for i < enq_n; tail <= tail + enq_n.
- Dequeue:
  - deq_eff = min(deq_cnt, count). An over-request is clamped, never underflows, and is flagged by the simulation assertion.
  - head <= head + deq_eff.
- Presentation:
  - out_valid[k] = (count > k).
  - out_data lane k = mem[(head+k) mod DEPTH].
  - Zero latency: an entry written at edge N is visible on out_* after edge N.
- count <= count + enq_acc - deq_eff, where enq_acc = enq_n if in_ready else 0. Simultaneous enqueue and dequeue are supported in the same cycle.
- Flush has priority over enqueue and dequeue in the same cycle: head=tail=count=0, and the enqueue that cycle is discarded. Reset has priority over flush.
- Wrap-around: pointer arithmetic is modulo DEPTH. Bursts that straddle index DEPTH-1→0 must write and read correctly.
- Bypass: none. An entry arriving while the queue is empty is presented the following cycle.
- Assertions (simulation only):
  - deq_cnt > count.
  - in_valid not prefix-contiguous.
  - A dequeue that retires lane k while out_valid[k]=0.

Decomposition:
- Shared package/header:
  - lane-count and bus-width constants (DECODE_BUS_WD reused as DATA_W default);
  - pointer/count width functions (clog2);
  - the SINGLE/DUAL issue-mode encodings generalised to an issue-count field.
- One natural sub-module: issue_queue_lane_mux, a DEQ_N-way read-port mux computing head+k with wrap. It is instantiated once per output lane.
- Enqueue prefix-count logic stays inline.

Test Plan:
- Reset mid-burst: with count=5, assert reset for 1 cycle → count=0, empty=1, out_valid=0, in_ready=1 immediately, before the next edge.
- Fill to full: DEPTH=16, 2-lane bursts every cycle with deq_cnt=0 → 8 accepts; almost_full asserts when count reaches 12; in_ready=0 at count≥15 and stays 0 at count=16; full=1; no overwrite of entry 0.
- Wrap:
  - Setup: enqueue 14, dequeue 14, then enqueue data 0xA,0xB.
  - Expect: tail crosses 15→0, out_data lane0=0xA and lane1=0xB, count=2.
- Simultaneous traffic: count=3, enqueue 2 with deq_cnt=2 → count=3 next cycle, head+2, order preserved.
- Clamp and prefix: count=1 with deq_cnt=2 → count=0 and head+1. in_valid=2'b10 → nothing enqueued.
- Flush priority: flush=1 together with an enqueue of 2 and deq_cnt=1 at count=6 → count=0, empty=1; next enqueue lands at index 0.
